seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Downstream consumer of the MM:SS BCD digit counter. Time-multiplexes four BCD digits onto one
//  active-low 7-segment bus with active-low anodes. Adds frame-synchronous digit snapshot (no
//  tearing), leading-zero blanking, a colon dot and a whole-display blink for alarm/expiry.
// PARAMETERS
//  SCAN_BITS   17  width of scan counter; dwell per digit = 2^(SCAN_BITS-2) clk cycles (>=3)
//  BLINK_BITS  26  width of blink counter; display on/off half-period = 2^(BLINK_BITS-1) cycles
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  reset     in   1  synchronous, active-high
//  d0..d3    in   4  BCD digits each; d0 = seconds units (rightmost), d3 = tens of minutes
//  blank_lz  in   1  1 = blank leading zeros (d3, then d2, then d1; never d0)
//  dp_en     in   1  1 = light decimal point on digit 2 (colon position)
//  blink_en  in   1  1 = whole display blinks at blink rate
//  seg       out  7  active-low segments, seg[0]=a ... seg[6]=g
//  dp        out  1  active-low decimal point
//  AN        out  4  active-low anodes, AN[0] = digit d0
//  frame_start out 1 one-cycle pulse coincident with first output cycle of digit 0 each frame
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-frame): scan_cnt=0, blink_cnt=0, shadow digits=0; next edge
//    drives AN=4'b1111, seg=7'h7F, dp=1, frame_start=0.
//  - scan_cnt: free-running SCAN_BITS counter, wraps max->0. sel = scan_cnt[SCAN_BITS-1 -: 2].
//  - Snapshot: on the edge where scan_cnt==all-ones, shadow<=d0..d3. Input changes mid-frame
//    are invisible until the following frame.
//  - Outputs registered: 1-cycle latency. Outputs in cycle t+1 reflect sel and shadow at t.
//    sel 0..3 -> AN = ~(4'b0001 << sel) unless digit is blanked (then AN=4'b1111, seg=7'h7F).
//  - Decode (active-low {g..a}): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//    5=0010010 6=0000010 7=1111000 8=0000000 9=0010000; 10..15 -> '-' = 0111111.
//  - Leading-zero blank (blank_lz=1): d3 blank if d3==0; d2 blank if d3==0&&d2==0;
//    d1 blank if d3==d2==d1==0; d0 always shown (0000 displays "0").
//  - dp=0 only when sel==2, dp_en=1, digit 2 not blanked and display not blinked off.
//    dp is blanked together with digit 2's anode.
//  - blink_cnt: free-running BLINK_BITS counter. When blink_en=1 and blink_cnt MSB=1, output
//    AN=4'b1111, seg=7'h7F, dp=1 (counters keep running). blink_en=0 takes effect next output.
//  - frame_start=1 in the output cycle showing digit 0 after scan_cnt wraps to 0. The first
//    frame after reset also pulses.
//  - blank_lz/dp_en/blink_en are sampled live, not snapshotted.
// STRUCTURE
//  - Shared package: SEG_BLANK=7'h7F, SEG_DASH=7'b0111111, AN_OFF=4'b1111, digit-encoding
//    table constants.
//  - One sub-module: bcd_to_seg (combinational 4-bit -> 7-bit active-low decoder).
//  - Top: scan counter, blink counter, shadow regs, blank logic, output regs.
// TESTING (bench: SCAN_BITS=4 -> 4-cycle dwell; BLINK_BITS=6 -> 32-cycle half-period)
//  1. Hold reset 3 cycles -> AN=1111, seg=7F, dp=1. Release with d=0, blank_lz=0 ->
//     next cycle AN=1110, seg=1000000, frame_start=1 for exactly one cycle.
//  2. d3..d0=1,2,3,4 across a frame boundary -> AN 1110/1101/1011/0111, 4 cycles each.
//     seg matches: d0=4 -> 0011001, d1=3 -> 0110000, d2=2 -> 0100100, d3=1 -> 1111001.
//  3. Change d0 4->7 mid-frame at sel=1 -> digit 0 still shows 0011001 until next frame,
//     then 1111000.
//  4. blank_lz=1, d=0,0,0,5 -> AN=1110 with seg=0010010 in slot 0, AN=1111 in slots 1-3.
//     With d=0,0,0,0 -> slot 0 shows 1000000.
//  5. d1=4'hC, dp_en=1 -> slot 1 seg=0111111; dp=0 only while AN=1011.
//  6. blink_en=1 -> 32 cycles normal scanning, 32 cycles AN=1111/dp=1, repeat. Assert reset
//     mid-blank -> next cycle all off, then normal scan restarts at digit 0 with frame_start.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver: segment patterns,
// the blank/off codes and the digit-to-anode helper.
package seg_scan_driver_pkg;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    function automatic logic [3:0] an_for_sel(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit/control inputs and display outputs of the scan driver as one bundle;
// the master side supplies digits, the slave side is the driver itself.
interface seg_scan_driver_if;
    import seg_scan_driver_pkg::*;

    bcd_t       d0;
    bcd_t       d1;
    bcd_t       d2;
    bcd_t       d3;
    logic       blank_lz;
    logic       dp_en;
    logic       blink_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] AN;
    logic       frame_start;

    modport master (
        output d0, d1, d2, d3, blank_lz, dp_en, blink_en,
        input  seg, dp, AN, frame_start
    );

    modport slave (
        input  d0, d1, d2, d3, blank_lz, dp_en, blink_en,
        output seg, dp, AN, frame_start
    );

endinterface

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg
    import seg_scan_driver_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed 7-segment driver with frame-synchronous snapshot,
// leading-zero blanking, colon dot and whole-display blink.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_BITS  = 17,
    parameter int BLINK_BITS = 26
)(
    input  logic              clk,
    input  logic              reset,
    seg_scan_driver_if.slave  bus
);

    logic [SCAN_BITS-1:0]  scan_cnt_reg;
    logic [BLINK_BITS-1:0] blink_cnt_reg;
    bcd_t                  shadow_reg [NUM_DIGITS];
    bcd_t                  live_digit [NUM_DIGITS];
    logic [6:0]            dec_seg    [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank;
    logic                  lz_run;
    logic [1:0]            sel;
    logic                  blink_off;

    logic [6:0] seg_reg, seg_next;
    logic [3:0] an_reg,  an_next;
    logic       dp_reg,  dp_next;
    logic       fs_reg,  fs_next;

    assign live_digit[0] = bus.d0;
    assign live_digit[1] = bus.d1;
    assign live_digit[2] = bus.d2;
    assign live_digit[3] = bus.d3;

    assign sel       = scan_cnt_reg[SCAN_BITS-1 -: 2];
    assign blink_off = bus.blink_en && blink_cnt_reg[BLINK_BITS-1];

    // Decoders run off the snapshot so a digit can't change under its own dwell.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
            bcd_to_seg u_dec (
                .digit (shadow_reg[gi]),
                .seg   (dec_seg[gi])
            );
        end
    endgenerate

    // A digit is blanked only while it and every more-significant digit are zero.
    always_comb begin
        blank  = '0;
        lz_run = bus.blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run   = lz_run && (shadow_reg[i] == 4'd0);
            blank[i] = lz_run;
        end
    end

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        fs_next  = (scan_cnt_reg == '0);
        if (!blink_off && !blank[sel]) begin
            an_next  = an_for_sel(sel);
            seg_next = dec_seg[sel];
            dp_next  = !((sel == 2'd2) && bus.dp_en);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_reg  <= '0;
            blink_cnt_reg <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) shadow_reg[i] <= '0;
            an_reg  <= AN_OFF;
            seg_reg <= SEG_BLANK;
            dp_reg  <= 1'b1;
            fs_reg  <= 1'b0;
        end else begin
            scan_cnt_reg  <= scan_cnt_reg + 1'b1;
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
            // Capture on the last cycle of a frame so the next frame is coherent.
            if (&scan_cnt_reg) begin
                for (int i = 0; i < NUM_DIGITS; i++) shadow_reg[i] <= live_digit[i];
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            fs_reg  <= fs_next;
        end
    end

    assign bus.AN          = an_reg;
    assign bus.seg         = seg_reg;
    assign bus.dp          = dp_reg;
    assign bus.frame_start = fs_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver: a cycle-indexed display model checks every
// output cycle, and literal expectations pin the model on the key scenarios.
module tb_seg_scan_driver;

    localparam int SCAN_BITS  = 4;
    localparam int BLINK_BITS = 6;
    localparam int PERIOD     = 1 << SCAN_BITS;
    localparam int DWELL      = PERIOD / 4;
    localparam int HALF       = 1 << (BLINK_BITS - 1);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seg_scan_driver_if bus ();

    seg_scan_driver #(.SCAN_BITS(SCAN_BITS), .BLINK_BITS(BLINK_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] dec_tbl [16];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       exp_fs;
    logic       model_valid = 1'b0;
    int         k;
    logic [3:0] sh [4];

    initial begin
        dec_tbl[0] = 7'b1000000; dec_tbl[1] = 7'b1111001; dec_tbl[2] = 7'b0100100;
        dec_tbl[3] = 7'b0110000; dec_tbl[4] = 7'b0011001; dec_tbl[5] = 7'b0010010;
        dec_tbl[6] = 7'b0000010; dec_tbl[7] = 7'b1111000; dec_tbl[8] = 7'b0000000;
        dec_tbl[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) dec_tbl[i] = 7'b0111111;
    end

    // Model: k counts clean cycles since reset; position in frame and blink phase follow from it.
    always @(posedge clk) begin : model
        int  pos, digit, lead;
        logic off, bl;
        if (reset) begin
            k = 0;
            for (int i = 0; i < 4; i++) sh[i] = 4'd0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            pos   = k % PERIOD;
            digit = pos / DWELL;
            lead  = 0;
            for (int i = 0; i < 4; i++) if (sh[i] != 4'd0) lead = i;
            bl  = bus.blank_lz && (digit > lead);
            off = bus.blink_en && (((k / HALF) % 2) == 1);
            exp_fs = (pos == 0);
            if (off || bl) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an        = 4'hF;
                exp_an[digit] = 1'b0;
                exp_seg       = dec_tbl[sh[digit]];
                exp_dp        = !(digit == 2 && bus.dp_en);
            end
            if (pos == PERIOD - 1) begin
                sh[0] = bus.d0; sh[1] = bus.d1; sh[2] = bus.d2; sh[3] = bus.d3;
            end
            k++;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            total++;
            if ({bus.AN, bus.seg, bus.dp, bus.frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                bad++;
                $display("FAIL cycle t=%0t got AN=%b seg=%b dp=%b fs=%b want AN=%b seg=%b dp=%b fs=%b",
                         $time, bus.AN, bus.seg, bus.dp, bus.frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("check %s = %h", name, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) return;
        end
        total++;
        bad++;
        $display("FAIL wait_fs no frame_start within %0d cycles got=0 want=1", 3 * PERIOD);
    endtask

    task automatic set_digits(input logic [3:0] a3, input logic [3:0] a2,
                              input logic [3:0] a1, input logic [3:0] a0);
        bus.d3 = a3; bus.d2 = a2; bus.d1 = a1; bus.d0 = a0;
    endtask

    initial begin
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        bus.blank_lz = 1'b0; bus.dp_en = 1'b0; bus.blink_en = 1'b0;

        // Reset state and first frame after release
        cyc(3);
        chk("reset_an", 16'(bus.AN), 16'hF);
        chk("reset_seg", 16'(bus.seg), 16'h7F);
        chk("reset_dp_fs", 16'({bus.dp, bus.frame_start}), 16'b10);
        reset = 1'b0;
        cyc(1);
        chk("first_an", 16'(bus.AN), 16'hE);
        chk("first_seg", 16'(bus.seg), 16'h40);
        chk("first_fs", 16'(bus.frame_start), 16'h1);
        cyc(1);
        chk("fs_one_cycle", 16'(bus.frame_start), 16'h0);

        // Digits 1,2,3,4 take effect at the next frame
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        wait_fs();
        chk("d0_4", 16'({bus.AN, bus.seg}), 16'({4'hE, 7'b0011001}));
        cyc(DWELL);
        chk("d1_3", 16'({bus.AN, bus.seg}), 16'({4'hD, 7'b0110000}));
        cyc(DWELL);
        chk("d2_2", 16'({bus.AN, bus.seg}), 16'({4'hB, 7'b0100100}));
        cyc(DWELL);
        chk("d3_1", 16'({bus.AN, bus.seg}), 16'({4'h7, 7'b1111001}));

        // Mid-frame change of d0 is held back until the next frame
        wait_fs();
        cyc(DWELL);
        bus.d0 = 4'd7;
        cyc(DWELL);
        chk("held_d2", 16'({bus.AN, bus.seg}), 16'({4'hB, 7'b0100100}));
        wait_fs();
        chk("d0_7", 16'({bus.AN, bus.seg}), 16'({4'hE, 7'b1111000}));

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        set_digits(4'd0, 4'd0, 4'd0, 4'd5);
        wait_fs();
        chk("lz_slot0", 16'({bus.AN, bus.seg}), 16'({4'hE, 7'b0010010}));
        cyc(DWELL);
        chk("lz_slot1", 16'({bus.AN, bus.seg}), 16'({4'hF, 7'h7F}));
        cyc(2 * DWELL);
        chk("lz_slot3", 16'({bus.AN, bus.seg}), 16'({4'hF, 7'h7F}));
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        wait_fs();
        chk("lz_zero", 16'({bus.AN, bus.seg}), 16'({4'hE, 7'b1000000}));

        // Dash for invalid code and colon dot on digit 2
        bus.blank_lz = 1'b0;
        bus.dp_en    = 1'b1;
        set_digits(4'd1, 4'd2, 4'hC, 4'd4);
        wait_fs();
        cyc(DWELL);
        chk("dash_slot1", 16'({bus.AN, bus.seg, bus.dp}), 16'({4'hD, 7'b0111111, 1'b1}));
        cyc(DWELL);
        chk("dp_slot2", 16'({bus.AN, bus.dp}), 16'({4'hB, 1'b0}));
        cyc(DWELL);
        chk("dp_slot3", 16'({bus.AN, bus.dp}), 16'({4'h7, 1'b1}));

        // Blink phases, then reset in the middle of an off phase
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        bus.blink_en = 1'b1;
        bus.dp_en    = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            cyc(1);
            if (i == 1)  chk("blink_on_start", 16'({bus.AN, bus.frame_start}), 16'({4'hE, 1'b1}));
            if (i == 32) chk("blink_on_end", 16'(bus.AN), 16'h7);
            if (i == 33) chk("blink_off_start", 16'({bus.AN, bus.seg, bus.dp}), 16'({4'hF, 7'h7F, 1'b1}));
            if (i == 65) chk("blink_on_again", 16'({bus.AN, bus.frame_start}), 16'({4'hE, 1'b1}));
            if (i == 100) chk("blink_off_again", 16'(bus.AN), 16'hF);
        end
        reset = 1'b1;
        cyc(1);
        chk("midblank_reset", 16'({bus.AN, bus.seg, bus.dp, bus.frame_start}), 16'({4'hF, 7'h7F, 2'b10}));
        reset = 1'b0;
        cyc(1);
        chk("restart_digit0", 16'({bus.AN, bus.frame_start}), 16'({4'hE, 1'b1}));

        // Randomized traffic checked by the model
        for (int r = 0; r < 40; r++) begin
            int hold;
            bus.d0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bus.d1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bus.d2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bus.d3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            bus.blank_lz = 1'($urandom_range(0, 1));
            bus.dp_en    = 1'($urandom_range(0, 1));
            bus.blink_en = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(1, 40);
            $display("round %0d d=%h%h%h%h lz=%0b dp=%0b blink=%0b hold=%0d",
                     r, bus.d3, bus.d2, bus.d1, bus.d0, bus.blank_lz, bus.dp_en, bus.blink_en, hold);
            if (r % 13 == 12) begin
                reset = 1'b1;
                cyc(1);
                reset = 1'b0;
            end
            cyc(hold);
        end

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
